reg_block_streamer: RTL and testbench

//  Read-side sequencer for Reg_Block. On a start command it walks COUNT consecutive
//  Reg_Block read addresses from BASE, captures Data_Out, and streams the words on a

---
 rtl/reg_block_streamer.sv | 178 +++++++++++++++++
 tb/tb_reg_block_streamer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_block_streamer.sv
// ---------------------------------------------------------------------------
// reg_block_streamer
//   Read-side sequencer for Reg_Block. A start command makes the block read
//   `count` consecutive addresses from `base_addr`. The address wraps modulo
//   2^ADDR_W. Each returned Data_Out word is captured into a small output FIFO,
//   and the FIFO is streamed on a valid/ready interface. A read is issued only
//   while the FIFO has room for it and for every read already in flight, so
//   back-pressure never drops a word.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             1-cycle command strobe, only accepted while idle
//   base_addr, count  command operands, sampled together with start
//   busy, done        busy from the cycle after start until done;
//                     done is a 1-cycle pulse after the last word is accepted
//   Addr_Out          read address to Reg_Block
//   Data_Out          read data from Reg_Block, valid READ_LAT cycles after Addr_Out
//   m_data, m_valid   output stream (FIFO head)
//   m_ready           output stream ready
// ---------------------------------------------------------------------------
module reg_block_streamer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 7,
    parameter int READ_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] Addr_Out,
    input  logic [DATA_W-1:0] Data_Out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_addr;        // next address to issue
    logic [ADDR_W-1:0]   r_addr_out;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_issued;
    logic [ADDR_W:0]     w_issued_next;
    logic [READ_LAT-1:0] r_tag;         // one bit per read still travelling through Reg_Block

    logic [DATA_W-1:0]   r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_fifo_cnt;

    logic [CNT_W-1:0]    w_inflight;
    logic [CRD_W-1:0]    w_credit_used;
    logic                w_issue;
    logic                w_fifo_wr;
    logic                w_fifo_rd;

    // Credits: every word already in the FIFO or in flight owns one FIFO slot,
    // so a new read is only launched when a slot is still unclaimed.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            w_inflight = w_inflight + CNT_W'(r_tag[i]);
        end
    end

    assign w_credit_used = CRD_W'(r_fifo_cnt) + CRD_W'(w_inflight);
    assign w_issue       = (r_state == S_ISSUE) && (r_issued != r_count) &&
                           (w_credit_used < CRD_W'(FIFO_DEPTH));
    assign w_issued_next = r_issued + (ADDR_W + 1)'(w_issue);

    assign w_fifo_wr = r_tag[READ_LAT-1];
    assign w_fifo_rd = m_valid && m_ready;

    // NOTE: every signal written in this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (w_issued_next == r_count) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if ((w_inflight == '0) && (r_fifo_cnt == '0)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_addr_out <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_tag      <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && start) begin
                r_addr   <= base_addr;
                r_count  <= count;
                r_issued <= '0;
            end else if (w_issue) begin
                r_addr_out <= r_addr;
                r_addr     <= r_addr + ADDR_W'(1);  // wraps modulo 2^ADDR_W
                r_issued   <= w_issued_next;
            end
            r_tag[0] <= w_issue;
            for (int i = 1; i < READ_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_fifo_wr) - CNT_W'(w_fifo_rd);
        end
    end

    // NOTE: FIFO storage is not reset. The empty flag comes from the reset
    // pointers and count, and m_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_fifo_mem[r_wr_ptr] <= Data_Out;
        end
    end

    assign m_valid  = (r_fifo_cnt != '0);
    assign m_data   = m_valid ? r_fifo_mem[r_rd_ptr] : '0;
    assign Addr_Out = r_addr_out;

endmodule

// File: tb/tb_reg_block_streamer.sv
// ---------------------------------------------------------------------------
// tb_reg_block_streamer
//   Self-checking bench for reg_block_streamer.
//   - Reg_Block is modelled as a 128-word array with a combinational read,
//     which gives READ_LAT = 1.
//   - A table of commands is checked against hand-derived first and last
//     words and the final Addr_Out.
//   - Hand-written sequences cover back-pressure hold, count = 0, start while
//     busy, and reset in the middle of a transfer.
//   - Random commands with random m_ready are checked against a reference
//     model. The model computes the expected stream as
//     mem[(base + i) mod 128] for i = 0 .. count-1.
// ---------------------------------------------------------------------------
module tb_reg_block_streamer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 7;
    localparam int NWORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] Addr_Out;
    logic [DATA_W-1:0] Data_Out;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    logic [DATA_W-1:0] mem [NWORDS];
    logic [DATA_W-1:0] got_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    reg_block_streamer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .count(count), .busy(busy), .done(done), .Addr_Out(Addr_Out),
        .Data_Out(Data_Out), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    assign Data_Out = mem[Addr_Out];

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   cnt;
        int                mode;      // 0: always ready, 1: toggling ready
        logic [DATA_W-1:0] exp_first;
        logic [DATA_W-1:0] exp_last;
        logic [ADDR_W-1:0] exp_addr;  // Addr_Out left after the last issue
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        got_q.delete();
        start     = 1'b1;
        base_addr = b;
        count     = c;
        tick();
        start = 1'b0;
    endtask

    // Runs until done is seen or the budget expires. A stray start can be
    // injected at cycle inject_cyc to prove it is ignored.
    task automatic collect(input int mode, input int budget, input int inject_cyc,
                           output bit finished, output int first_cyc, output int last_cyc);
        finished  = 1'b0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            start = (cyc == inject_cyc);
            if (start) begin
                base_addr = 7'd50;
                count     = 8'd2;
            end
            @(negedge clk);
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (done) finished = 1'b1;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic post_done(input string tag);
        @(negedge clk);
        check({tag, " done falls"}, done, 0);
        check({tag, " busy falls"}, busy, 0);
        check({tag, " m_valid idle"}, m_valid, 0);
        tick();
    endtask

    // Reference model: the expected stream is the wrapped address range.
    task automatic compare_model(input string tag, input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        check({tag, " word count"}, got_q.size(), c);
        for (int i = 0; i < int'(c) && i < got_q.size(); i++) begin
            check($sformatf("%s word %0d", tag, i), got_q[i], mem[(int'(b) + i) % NWORDS]);
        end
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < NWORDS; a++) mem[a] = DATA_W'(a + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              vecs[5];
        bit                fin;
        int                fc, lc;
        logic [DATA_W-1:0] w;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        bit                moved;
        bit                saw_done;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W:0]   rc;

        vecs[0] = '{7'd0,   8'd4,   0, 16'd1,   16'd4,  7'd3};
        vecs[1] = '{7'd126, 8'd4,   0, 16'd127, 16'd2,  7'd1};
        vecs[2] = '{7'd20,  8'd16,  1, 16'd21,  16'd36, 7'd35};
        vecs[3] = '{7'd127, 8'd1,   0, 16'd128, 16'd128, 7'd127};
        vecs[4] = '{7'd5,   8'd128, 0, 16'd6,   16'd5,  7'd4};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b0;
        fill_ramp();
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset m_valid", m_valid, 0);
        check("reset Addr_Out", Addr_Out, 0);
        check("reset m_data", m_data, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven commands (ramp contents: mem[a] = a + 1).
        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            start_cmd(vecs[v].base, vecs[v].cnt);
            collect(vecs[v].mode, int'(vecs[v].cnt) * 6 + 40, -1, fin, fc, lc);
            check({tag, " done seen"}, fin, 1);
            w = 'x;
            if (got_q.size() > 0) w = got_q[0];
            check({tag, " first word"}, w, vecs[v].exp_first);
            w = 'x;
            if (got_q.size() > 0) w = got_q[got_q.size() - 1];
            check({tag, " last word"}, w, vecs[v].exp_last);
            check({tag, " final Addr_Out"}, Addr_Out, vecs[v].exp_addr);
            if (vecs[v].mode == 0) check({tag, " back-to-back"}, lc - fc, int'(vecs[v].cnt) - 1);
            compare_model(tag, vecs[v].base, vecs[v].cnt);
            post_done(tag);
        end

        // Back-pressure: only FIFO_DEPTH reads may issue, then everything holds.
        m_ready = 1'b0;
        start_cmd(7'd10, 8'd8);
        repeat (12) tick();
        @(negedge clk);
        a0 = Addr_Out;
        d0 = m_data;
        check("stall Addr_Out", a0, 13);
        check("stall m_valid", m_valid, 1);
        check("stall m_data", d0, mem[10]);
        moved = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            if (Addr_Out !== a0 || m_data !== d0 || m_valid !== 1'b1) moved = 1'b1;
        end
        check("stall hold", moved, 0);
        tick();
        collect(0, 60, -1, fin, fc, lc);
        check("stall done seen", fin, 1);
        compare_model("stall", 7'd10, 8'd8);
        post_done("stall");

        // count == 0: no reads, done the cycle after start.
        m_ready = 1'b1;
        a0 = Addr_Out;
        start_cmd(7'd33, 8'd0);
        @(negedge clk);
        check("zero done", done, 1);
        check("zero busy", busy, 1);
        check("zero m_valid", m_valid, 0);
        check("zero Addr_Out", Addr_Out, a0);
        tick();
        @(negedge clk);
        check("zero done falls", done, 0);
        check("zero busy falls", busy, 0);
        check("zero Addr_Out held", Addr_Out, a0);
        tick();

        // A start while busy is ignored.
        start_cmd(7'd0, 8'd4);
        collect(0, 60, 2, fin, fc, lc);
        check("ignore done seen", fin, 1);
        compare_model("ignore", 7'd0, 8'd4);
        post_done("ignore");
        moved = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || m_valid || done) moved = 1'b1;
            tick();
        end
        check("ignore stays idle", moved, 0);

        // Reset in the middle of a stalled transfer aborts it.
        m_ready = 1'b0;
        start_cmd(7'd10, 8'd8);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("abort m_valid", m_valid, 0);
        check("abort busy", busy, 0);
        check("abort Addr_Out", Addr_Out, 0);
        check("abort done", done, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy || m_valid) saw_done = 1'b1;
            tick();
        end
        check("abort no done", saw_done, 0);
        start_cmd(7'd0, 8'd4);
        collect(0, 60, -1, fin, fc, lc);
        check("after abort done seen", fin, 1);
        check("after abort back-to-back", lc - fc, 3);
        compare_model("after abort", 7'd0, 8'd4);
        post_done("after abort");

        // Random commands against the reference model.
        for (int r = 0; r < 12; r++) begin
            for (int a = 0; a < NWORDS; a++) mem[a] = DATA_W'($urandom);
            rb = ADDR_W'($urandom_range(0, NWORDS - 1));
            rc = (r == 0) ? 8'd128 : (ADDR_W + 1)'($urandom_range(1, 40));
            start_cmd(rb, rc);
            collect(2, int'(rc) * 12 + 60, -1, fin, fc, lc);
            check($sformatf("rnd%0d done seen", r), fin, 1);
            compare_model($sformatf("rnd%0d", r), rb, rc);
            post_done($sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
